// File: rtl/lcd_write_sched.sv
// Write scheduler for an HD44780 character LCD: runs the power-up command sequence,
// then drains a 4-entry request FIFO onto the LCD bus with setup/pulse/settle timing.
module lcd_write_sched #(
    parameter int EN_CYC   = 50_000,
    parameter int GAP_CYC  = 50_000,
    parameter int LONG_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       EN,
    output logic       RW,
    output logic       RS,
    output logic [7:0] data
);

    localparam logic [1:0] ST_SETUP = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd3;

    localparam logic [2:0]  FIFO_DEPTH = 3'd4;
    localparam logic [2:0]  INIT_LAST  = 3'd3;
    localparam logic [31:0] PULSE_LAST = 32'(EN_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);
    localparam logic [31:0] LONG_LAST  = 32'(LONG_CYC - 1);

    // Power-up command sequence: function set, display on, clear, entry mode.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h0E;
            3'd2:    b = 8'h01;
            3'd3:    b = 8'h06;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [8:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  count_next;
    logic        push;
    logic        pop;
    logic [8:0]  fifo_head;

    // ------------------------------------------------------------------
    // Write sequencer state
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [31:0] cyc_cnt;
    logic [2:0]  init_idx;
    logic        cur_rs;
    logic [7:0]  cur_data;
    logic        long_wait;
    logic [31:0] wait_last;
    logic        pulse_done;
    logic        wait_done;

    assign push      = req_valid && req_ready;
    assign pop       = (state == ST_IDLE) && (count != 3'd0);
    assign fifo_head = fifo_mem[rd_ptr];

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 3'd1;
        end else if (pop && !push) begin
            count_next = count - 3'd1;
        end
    end

    // NOTE: the storage array carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_rs, req_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            req_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count     <= count_next;
            req_ready <= (count_next != FIFO_DEPTH);
        end
    end

    // Clear (0x01) and home (0x02/0x03) need the long settle time.
    assign long_wait  = !cur_rs && ((cur_data == 8'h01) || (cur_data == 8'h02) || (cur_data == 8'h03));
    assign wait_last  = long_wait ? LONG_LAST : GAP_LAST;
    assign pulse_done = (cyc_cnt == PULSE_LAST);
    assign wait_done  = (cyc_cnt == wait_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SETUP;
            cyc_cnt   <= 32'd0;
            init_idx  <= 3'd0;
            init_done <= 1'b0;
            cur_rs    <= 1'b0;
            cur_data  <= init_rom(3'd0);
        end else begin
            case (state)
                ST_SETUP: begin
                    cyc_cnt <= 32'd0;
                    state   <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (pulse_done) begin
                        cyc_cnt <= 32'd0;
                        state   <= ST_WAIT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 32'd1;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        cyc_cnt <= 32'd0;
                        if (!init_done) begin
                            init_idx <= init_idx + 3'd1;
                            if (init_idx == INIT_LAST) begin
                                init_done <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                cur_rs   <= 1'b0;
                                cur_data <= init_rom(init_idx + 3'd1);
                                state    <= ST_SETUP;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 32'd1;
                    end
                end
                default: begin
                    if (pop) begin
                        cur_rs   <= fifo_head[8];
                        cur_data <= fifo_head[7:0];
                        state    <= ST_SETUP;
                    end
                end
            endcase
        end
    end

    // Bus pins and busy are registered from the sequencer state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            EN   <= 1'b0;
            RS   <= 1'b0;
            data <= 8'h00;
            busy <= 1'b1;
        end else begin
            EN   <= (state == ST_PULSE);
            busy <= (state != ST_IDLE) || (count != 3'd0);
            if (state == ST_SETUP) begin
                RS   <= cur_rs;
                data <= cur_data;
            end
        end
    end

    assign RW = 1'b0;

endmodule

// File: tb/tb_lcd_write_sched.sv
// Scoreboard bench for lcd_write_sched: stimulus queues expected LCD writes,
// a monitor checks each EN pulse (byte, RS, pulse width, rise-to-rise spacing).
module tb_lcd_write_sched;

    localparam int EN_CYC   = 2;
    localparam int GAP_CYC  = 3;
    localparam int LONG_CYC = 6;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs    = 1'b0;
    logic [7:0] req_data  = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       en;
    logic       rw;
    logic       rs;
    logic [7:0] data;

    lcd_write_sched #(
        .EN_CYC  (EN_CYC),
        .GAP_CYC (GAP_CYC),
        .LONG_CYC(LONG_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .busy     (busy),
        .EN       (en),
        .RW       (rw),
        .RS       (rs),
        .data     (data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int rst_edge = 0;

    // gap: expected cycles from the previous EN rise to this one (0 = not checked)
    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       init;
        int         gap;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_write(input logic r, input logic [7:0] d, input logic init, input int gap);
        exp_t e;
        e.rs   = r;
        e.data = d;
        e.init = init;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        expect_write(1'b0, 8'h38, 1'b0, 0);
        expect_write(1'b0, 8'h0E, 1'b0, 6);
        expect_write(1'b0, 8'h01, 1'b0, 6);
        expect_write(1'b0, 8'h06, 1'b0, 9);
        @(posedge clk);
        #1;
        check("rst_en", en, 0);
        check("rst_rw", rw, 0);
        check("rst_rs", rs, 0);
        check("rst_data", data, 8'h00);
        check("rst_init_done", init_done, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 1);
        rst_edge = cyc;
        rst = 1'b0;
    endtask

    task automatic wait_init_done(input logic exp_busy_after);
        int n = 0;
        while (!init_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("init_done_seen", init_done, 1);
        check("init_cycles", cyc - rst_edge, 27);
        check("busy_at_init_done", busy, 1);
        @(negedge clk);
        check("busy_after_init_done", busy, exp_busy_after);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || en) && n < 300);
        check("idle_reached", busy, 0);
    endtask

    task automatic push(input logic r, input logic [7:0] d, input int gap, output int acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs    = r;
        req_data  = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", req_ready, 1);
        expect_write(r, d, 1'b1, gap);
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    // Monitor: every EN rise must match the head of the scoreboard.
    initial begin : monitor
        logic prev_en;
        int   rise_cyc;
        int   hi;
        exp_t e;
        prev_en  = 1'b0;
        rise_cyc = -1;
        hi       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en  = 1'b0;
                rise_cyc = -1;
                hi       = 0;
            end else begin
                if (en && !prev_en) begin
                    check("write_expected", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("bus_rs", rs, e.rs);
                        check("bus_data", data, e.data);
                        check("bus_rw", rw, 0);
                        check("init_done_at_write", init_done, e.init);
                        if (e.gap != 0 && rise_cyc >= 0) begin
                            check("en_spacing", cyc - rise_cyc, e.gap);
                        end
                    end
                    rise_cyc = cyc;
                    hi       = 1;
                end else if (en) begin
                    hi++;
                end else if (prev_en) begin
                    check("en_high_len", hi, EN_CYC);
                end
                prev_en = en;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int acc;
        int n;

        // Power-up sequence with no requests
        do_reset();
        wait_init_done(1'b0);
        wait_idle();

        // Single character write: latency and busy release
        push(1'b1, 8'h41, 0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("lat_rs", rs, 1);
        check("lat_data", data, 8'h41);
        check("lat_en_low", en, 0);
        @(posedge clk);
        #1;
        check("lat_en_high", en, 1);
        repeat (4) @(posedge clk);
        #1;
        check("busy_in_wait", busy, 1);
        @(posedge clk);
        #1;
        check("busy_low", busy, 0);
        wait_idle();

        // Five back-to-back requests; first is popped while the rest fill the FIFO
        for (int i = 0; i < 5; i++) begin
            push(1'(i % 2), 8'(8'h61 + i), (i == 0) ? 0 : 7, acc);
        end
        check("full_after_5th", req_ready, 0);
        wait_idle();
        check("sb_empty_b2b", sb.size(), 0);

        // Long settle after clear/home, short after characters
        push(1'b0, 8'h01, 0, acc);
        push(1'b1, 8'h30, 10, acc);
        push(1'b0, 8'h02, 7, acc);
        push(1'b1, 8'h31, 10, acc);
        wait_idle();
        check("sb_empty_long", sb.size(), 0);

        // Requests accepted during init are served after it
        do_reset();
        push(1'b1, 8'h48, 7, acc);
        push(1'b1, 8'h49, 7, acc);
        wait_init_done(1'b1);
        wait_idle();
        check("sb_empty_during_init", sb.size(), 0);

        // Reset mid-pulse with two entries queued
        push(1'b1, 8'h51, 0, acc);
        push(1'b1, 8'h52, 7, acc);
        push(1'b1, 8'h53, 7, acc);
        n = 0;
        while (!en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen", en, 1);
        @(posedge clk);
        #1;
        check("mid_pulse", en, 1);
        do_reset();
        wait_init_done(1'b0);
        wait_idle();
        repeat (20) @(negedge clk);
        check("sb_empty_after_abort", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
